// File: rtl/dmb_util_pkg.sv
// dmb_util_pkg: shared helpers for DAQ/trigger building blocks
package dmb_util_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic bit srl_params_ok(input int w, input int depth, input int aw);
        return w >= 1 && w <= 64 && depth >= 2 && depth <= 256 && (1 << aw) >= depth;
    endfunction
endpackage

// File: rtl/sat_upcnt.sv
// sat_upcnt: saturating up-counter with synchronous reset and enable
module sat_upcnt #(
    parameter int N   = 5,
    parameter int MAX = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic [N-1:0] Q
);
    always_ff @(posedge CLK)
        if (RST) Q <= '0;
        else if (EN && Q != N'(MAX)) Q <= Q + 1'b1;
endmodule

// File: rtl/srl_delay_nxw.sv
// srl_delay_nxw: W-bit CE-gated shift line with dynamic tap, last-stage tap and fill-tracked valid
module srl_delay_nxw
    import dmb_util_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int OREG  = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic [AW-1:0] A,
    input  logic [W-1:0]  I,
    output logic [W-1:0]  O,
    output logic          VLD,
    output logic [W-1:0]  QL
);
    localparam int FW = clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    if (!srl_params_ok(W, DEPTH, AW)) begin : g_bad
        $error("srl_delay_nxw: illegal W/DEPTH/AW combination");
    end
    (* syn_srlstyle = "select_srl" *) logic [W-1:0] sr [DEPTH];
    logic [FW-1:0] fill;
    logic [AW-1:0] ae;
    logic          vld_c;
    logic [W-1:0]  o_c;
    always_ff @(posedge CLK)
        if (CE) begin
            sr[0] <= I;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    sat_upcnt #(.N(FW), .MAX(DEPTH)) u_fill (.CLK(CLK), .RST(RST), .EN(CE), .Q(fill));
    // Clamp keeps the read inside the array for any A
    always_comb begin
        ae    = (A > LAST) ? LAST : A;
        vld_c = 32'(fill) > 32'(ae);
        o_c   = vld_c ? sr[ae] : '0;
    end
    assign QL = sr[DEPTH-1];
    if (OREG != 0) begin : g_oreg
        always_ff @(posedge CLK)
            if (RST) begin
                O   <= '0;
                VLD <= 1'b0;
            end else begin
                O   <= o_c;
                VLD <= vld_c;
            end
    end else begin : g_comb
        assign O   = o_c;
        assign VLD = vld_c;
    end
endmodule

// File: tb/tb_srl_delay_nxw.sv
// tb_srl_delay_nxw: scoreboard bench over three configurations sharing one data stream
module tb_srl_delay_nxw;
    logic       CLK = 0, RST = 1, CE = 0;
    logic [7:0] I = 0;
    logic [3:0] a1 = 0, a2 = 15, a3 = 0;
    logic [7:0] o1, o2, o3, q1, q2, q3;
    logic       v1, v2, v3;
    int checks = 0, errors = 0;
    int fa = 0, fb = 0, n = 0;
    logic [7:0] hist [$];
    logic [8:0] sb [$];

    always #5 CLK = ~CLK;

    srl_delay_nxw #(.W(8), .DEPTH(16), .AW(4), .OREG(0)) dut1 (.CLK(CLK), .RST(RST), .CE(CE), .A(a1), .I(I), .O(o1), .VLD(v1), .QL(q1));
    srl_delay_nxw #(.W(8), .DEPTH(12), .AW(4), .OREG(0)) dut2 (.CLK(CLK), .RST(RST), .CE(CE), .A(a2), .I(I), .O(o2), .VLD(v2), .QL(q2));
    srl_delay_nxw #(.W(8), .DEPTH(16), .AW(4), .OREG(1)) dut3 (.CLK(CLK), .RST(RST), .CE(CE), .A(a3), .I(I), .O(o3), .VLD(v3), .QL(q3));

    function automatic logic [8:0] tap(input int a, input int depth, input int fill);
        int   ae;
        logic v;
        ae = (a < depth) ? a : depth - 1;
        v  = fill > ae;
        return {v, v ? hist[ae] : 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] o, input logic v);
        logic [8:0] e;
        e = sb.pop_front();
        chk({tag, "_o"}, o, e[7:0]);
        chk({tag, "_vld"}, {7'h0, v}, {7'h0, e[8]});
    endtask

    task automatic step(input logic ce, input logic [7:0] i, input logic rst);
        logic [8:0] e3;
        CE = ce; I = i; RST = rst;
        e3 = rst ? 9'h0 : tap(a3, 16, fa);
        @(posedge CLK);
        if (ce) begin
            hist.push_front(i);
            if (hist.size() > 16) void'(hist.pop_back());
            n++;
        end
        fa = rst ? 0 : (ce && fa < 16) ? fa + 1 : fa;
        fb = rst ? 0 : (ce && fb < 12) ? fb + 1 : fb;
        sb.push_back(tap(a1, 16, fa));
        sb.push_back(tap(a2, 12, fb));
        sb.push_back(e3);
        #1;
        pop_chk("d16", o1, v1);
        pop_chk("d12", o2, v2);
        pop_chk("oreg", o3, v3);
        if (n >= 12) chk("ql12", q2, hist[11]);
        if (n >= 16) chk("ql16", q1, hist[15]);
    endtask

    task automatic comb_chk();
        sb.push_back(tap(a1, 16, fa));
        sb.push_back(tap(a2, 12, fb));
        #1;
        pop_chk("d16_a", o1, v1);
        pop_chk("d12_a", o2, v2);
    endtask

    initial begin
        #2;
        step(0, 8'h00, 1);
        step(1, 8'hAA, 1);
        step(0, 8'h00, 0);
        a1 = 4;
        comb_chk();
        for (int k = 1; k <= 20; k++) step(1, 8'(k), 0);
        a1 = 3;
        comb_chk();
        for (int k = 0; k < 3; k++) step(1, 8'($urandom_range(0, 255)), 0);
        a1 = 10;
        comb_chk();
        step(1, 8'h5A, 0);
        step(1, 8'hC3, 1);
        a1 = 2;
        for (int k = 0; k < 8; k++) step(k % 2 == 0, 8'(8'h30 + k), 0);
        step(0, 8'h00, 1);
        a1 = 3;
        for (int k = 0; k < 6; k++) step(1, 8'(8'h60 + k), 0);
        a1 = 10;
        comb_chk();
        for (int k = 0; k < 5; k++) step(1, 8'(8'h70 + k), 0);
        a1 = 1;
        comb_chk();
        for (int k = 0; k < 14; k++) step(1, 8'($urandom_range(0, 255)), 0);
        step(0, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 1);
        for (int k = 0; k < 4; k++) step(1, 8'(8'h90 + k), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
